// File: rtl/control_unit.sv
// control_unit: Moore sequencer for the 8-bit accumulator CPU.
// Latency: NOP 4 cycles, MOV/JMP 5, ALU/LDA/STA 6; each mem_rdy-low cycle in a memory state adds one.
// Backpressure: memory strobes are held until mem_rdy; optional timeout (UL8_WAIT_TIMEOUT_EN) halts with fault.
//
// Ports:
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   ir[7:0]           : instruction register (opcode ir[7:5], operand ir[4:0])
//   mem_rdy           : memory completion for the current mem_rd / mem_wr
//   bus_sel[2:0]      : bus source (0 akku,1 pc,2 mem,3 operand,4 pc+1,5 ir,6 alu,7 zero)
//   *_load            : one-hot register load enables
//   alu_op[1:0]       : ir[1:0] in the ALU states, else 0
//   mem_rd, mem_wr    : memory strobes
//   halted, fault     : HALT state indicator, HALT-by-timeout indicator
//
// Macro UL8_WAIT_TIMEOUT_EN adds a wait counter; after MEM_TIMEOUT cycles without
// mem_rdy the unit halts and raises fault. Without it the unit waits forever.
module control_unit #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic       mem_rdy,
    output logic [2:0] bus_sel,
    output logic       akku_load,
    output logic       pc_load,
    output logic       x_load,
    output logic       y_load,
    output logic       ar_load,
    output logic       ir_load,
    output logic [1:0] alu_op,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       halted,
    output logic       fault
);

    typedef enum logic [3:0] {
        F_AR, F_RD, F_INC, DEC, E_AR, E_LD, E_ST,
        E_MOV, E_ALU0, E_ALU1, E_JMP, HALT
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_STA  = 3'b010;
    localparam logic [2:0] OP_MOVX = 3'b011;
    localparam logic [2:0] OP_MOVY = 3'b100;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;

    state_t     r_state;
    logic [2:0] w_opcode;
    logic       w_in_wait;
    logic       w_timeout;
    logic       w_unused_ir;

    assign w_opcode    = ir[7:5];
    // Operand bits only reach the datapath via bus_sel=3, never the sequencer.
    assign w_unused_ir = ^ir[4:2];
    assign w_in_wait   = (r_state == F_RD) || (r_state == E_LD) || (r_state == E_ST);

`ifdef UL8_WAIT_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [7:0] r_wait;
    logic       r_fault;

    // r_wait holds the number of already-elapsed cycles of the current memory
    // access; it rests at 0 outside memory states, so entry starts from 0.
    // mem_rdy in the expiry cycle takes priority over the timeout.
    assign w_timeout = w_in_wait && !mem_rdy && (r_wait == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait  <= 8'd0;
            r_fault <= 1'b0;
        end else begin
            if (!w_in_wait || mem_rdy) begin
                r_wait <= 8'd0;
            end else begin
                r_wait <= r_wait + 8'd1;
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign fault = r_fault;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (MEM_TIMEOUT > 0);
    assign w_timeout        = 1'b0;
    assign fault            = 1'b0;
`endif

    // Next-state sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= F_AR;
        end else begin
            case (r_state)
                F_AR:  r_state <= F_RD;
                F_RD: begin
                    if (mem_rdy) begin
                        r_state <= F_INC;
                    end else if (w_timeout) begin
                        r_state <= HALT;
                    end
                end
                F_INC: r_state <= DEC;
                DEC: begin
                    case (w_opcode)
                        OP_NOP:           r_state <= F_AR;
                        OP_LDA, OP_STA:   r_state <= E_AR;
                        OP_MOVX, OP_MOVY: r_state <= E_MOV;
                        OP_ALU:           r_state <= E_ALU0;
                        OP_JMP:           r_state <= E_JMP;
                        default:          r_state <= HALT;
                    endcase
                end
                E_AR:  r_state <= (w_opcode == OP_LDA) ? E_LD : E_ST;
                E_LD, E_ST: begin
                    if (mem_rdy) begin
                        r_state <= F_AR;
                    end else if (w_timeout) begin
                        r_state <= HALT;
                    end
                end
                E_MOV:  r_state <= F_AR;
                E_ALU0: r_state <= E_ALU1;
                E_ALU1: r_state <= F_AR;
                E_JMP:  r_state <= F_AR;
                HALT:   r_state <= HALT;
                default: r_state <= F_AR;
            endcase
        end
    end

    // Output decode from state and ir. The loads that complete a memory read
    // additionally qualify on mem_rdy so the register samples valid data.
    // Everything is forced idle while rst_n is low, even though the state
    // register already sits in F_AR, so the first edge after release loads AR.
    always_comb begin
        bus_sel   = 3'd0;
        akku_load = 1'b0;
        pc_load   = 1'b0;
        x_load    = 1'b0;
        y_load    = 1'b0;
        ar_load   = 1'b0;
        ir_load   = 1'b0;
        alu_op    = 2'd0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        halted    = 1'b0;
        if (rst_n) begin
            case (r_state)
                F_AR: begin
                    bus_sel = 3'd1;
                    ar_load = 1'b1;
                end
                F_RD: begin
                    bus_sel = 3'd2;
                    mem_rd  = 1'b1;
                    ir_load = mem_rdy;
                end
                F_INC: begin
                    bus_sel = 3'd4;
                    pc_load = 1'b1;
                end
                E_AR: begin
                    bus_sel = 3'd3;
                    ar_load = 1'b1;
                end
                E_LD: begin
                    bus_sel   = 3'd2;
                    mem_rd    = 1'b1;
                    akku_load = mem_rdy;
                end
                E_ST: begin
                    bus_sel = 3'd0;
                    mem_wr  = 1'b1;
                end
                E_MOV: begin
                    bus_sel = 3'd0;
                    x_load  = (w_opcode == OP_MOVX);
                    y_load  = (w_opcode != OP_MOVX);
                end
                E_ALU0: begin
                    // Registered ALU needs one cycle before its result is valid.
                    alu_op = ir[1:0];
                end
                E_ALU1: begin
                    alu_op    = ir[1:0];
                    bus_sel   = 3'd6;
                    akku_load = 1'b1;
                end
                E_JMP: begin
                    bus_sel = 3'd3;
                    pc_load = 1'b1;
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    bus_sel = 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] ir;
    logic       mem_rdy;
    logic [2:0] bus_sel;
    logic       akku_load, pc_load, x_load, y_load, ar_load, ir_load;
    logic [1:0] alu_op;
    logic       mem_rd, mem_wr, halted, fault;

    control_unit #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .mem_rdy(mem_rdy),
        .bus_sel(bus_sel), .akku_load(akku_load), .pc_load(pc_load),
        .x_load(x_load), .y_load(y_load), .ar_load(ar_load), .ir_load(ir_load),
        .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .halted(halted), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output vector:
    // [14:12] bus_sel [11] akku [10] pc [9] x [8] y [7] ar [6] ir [5:4] alu_op
    // [3] mem_rd [2] mem_wr [1] halted [0] fault
    logic [14:0] act_now;
    assign act_now = {bus_sel, akku_load, pc_load, x_load, y_load, ar_load, ir_load,
                      alu_op, mem_rd, mem_wr, halted, fault};

    localparam logic [5:0] L_NONE = 6'b000000;
    localparam logic [5:0] L_AKKU = 6'b100000;
    localparam logic [5:0] L_PC   = 6'b010000;
    localparam logic [5:0] L_X    = 6'b001000;
    localparam logic [5:0] L_Y    = 6'b000100;
    localparam logic [5:0] L_AR   = 6'b000010;
    localparam logic [5:0] L_IR   = 6'b000001;
    localparam logic [14:0] CARE_ALL   = 15'h7fff;
    localparam logic [14:0] CARE_NOBUS = 15'h0fff;

    typedef struct {
        logic        rdy;
        logic [7:0]  irv;
        logic [14:0] exp;
        logic [14:0] care;
    } cyc_t;

    cyc_t        q[$];
    logic [14:0] act_log[$];
    logic [7:0]  prev_ir;
    int          total;
    int          bad;

    function automatic logic [14:0] ov(input logic [2:0] bs, input logic [5:0] ld,
                                       input logic [1:0] ao, input logic rd, input logic wr,
                                       input logic h, input logic f);
        return {bs, ld, ao, rd, wr, h, f};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rdy, input logic [7:0] irv, input logic [14:0] exp,
                        input logic [14:0] care);
        cyc_t c;
        c.rdy = rdy; c.irv = irv; c.exp = exp; c.care = care;
        q.push_back(c);
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Fetch phase: F_AR, read with wf wait cycles, PC increment, decode.
    task automatic add_fetch(input logic [7:0] nir, input int wf);
        push(rnd(), prev_ir, ov(3'd1, L_AR, 2'd0, 0, 0, 0, 0), CARE_ALL);
        for (int i = 0; i < wf; i++)
            push(1'b0, prev_ir, ov(3'd2, L_NONE, 2'd0, 1, 0, 0, 0), CARE_ALL);
        push(1'b1, prev_ir, ov(3'd2, L_IR, 2'd0, 1, 0, 0, 0), CARE_ALL);
        prev_ir = nir;
        push(rnd(), nir, ov(3'd4, L_PC, 2'd0, 0, 0, 0, 0), CARE_ALL);
        push(rnd(), nir, ov(3'd0, L_NONE, 2'd0, 0, 0, 0, 0), CARE_NOBUS);
    endtask

    task automatic add_halt(input int n, input logic f);
        for (int i = 0; i < n; i++)
            push(rnd(), prev_ir, ov(3'd0, L_NONE, 2'd0, 0, 0, 1, f), CARE_ALL);
    endtask

    // Whole instruction: wf = wait cycles on fetch, wm = wait cycles on data access.
    task automatic add_instr(input logic [7:0] nir, input int wf, input int wm);
        add_fetch(nir, wf);
        case (nir[7:5])
            3'd1, 3'd2: begin
                push(rnd(), nir, ov(3'd3, L_AR, 2'd0, 0, 0, 0, 0), CARE_ALL);
                for (int i = 0; i < wm; i++)
                    push(1'b0, nir, (nir[7:5] == 3'd1) ? ov(3'd2, L_NONE, 2'd0, 1, 0, 0, 0)
                                                       : ov(3'd0, L_NONE, 2'd0, 0, 1, 0, 0), CARE_ALL);
                push(1'b1, nir, (nir[7:5] == 3'd1) ? ov(3'd2, L_AKKU, 2'd0, 1, 0, 0, 0)
                                                   : ov(3'd0, L_NONE, 2'd0, 0, 1, 0, 0), CARE_ALL);
            end
            3'd3: push(rnd(), nir, ov(3'd0, L_X, 2'd0, 0, 0, 0, 0), CARE_ALL);
            3'd4: push(rnd(), nir, ov(3'd0, L_Y, 2'd0, 0, 0, 0, 0), CARE_ALL);
            3'd5: begin
                push(rnd(), nir, ov(3'd0, L_NONE, nir[1:0], 0, 0, 0, 0), CARE_NOBUS);
                push(rnd(), nir, ov(3'd6, L_AKKU, nir[1:0], 0, 0, 0, 0), CARE_ALL);
            end
            3'd6: push(rnd(), nir, ov(3'd3, L_PC, 2'd0, 0, 0, 0, 0), CARE_ALL);
            3'd7: add_halt(100, 1'b0);
            default: ;
        endcase
    endtask

    // Compare process: applies one queued cycle per clock and checks mid-cycle.
    task automatic run_n(input int n);
        cyc_t c;
        for (int k = 0; k < n && q.size() > 0; k++) begin
            c = q.pop_front();
            ir = c.irv;
            mem_rdy = c.rdy;
            @(negedge clk);
            total++;
            if ((act_now & c.care) !== (c.exp & c.care)) begin
                bad++;
                $display("FAIL cycle t=%0t ir=%h: outputs %h, expected %h (care %h)",
                         $time, c.irv, act_now, c.exp, c.care);
            end
            act_log.push_back(act_now);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_all();
        run_n(100000);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_immediate_idle", int'(act_now), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        prev_ir = ir;
    endtask

    function automatic int count_bit(input int b);
        int n = 0;
        foreach (act_log[i]) if (act_log[i][b]) n++;
        return n;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sz;
        logic [7:0] r_ir;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        ir = 8'hA3;
        mem_rdy = 1'b1;
        prev_ir = 8'h00;

        // Reset state: everything idle while rst_n low.
        repeat (2) begin
            @(negedge clk);
            chk("reset_idle", int'(act_now), 0);
        end
        ir = 8'h00;
        prev_ir = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // NOP stream straight after reset.
        add_instr(8'h00, 0, 0);
        chk("model_nop_len", q.size(), 4);
        add_instr(8'h00, 0, 0);
        act_log.delete();
        run_all();
        chk("nop_c1_ar_load", int'(act_log[0][7]), 1);
        chk("nop_c2_ir_load", int'(act_log[1][6]), 1);
        chk("nop_c3_pc_load", int'(act_log[2][10]), 1);
        chk("nop_c5_ar_load", int'(act_log[4][7]), 1);

        // LDA 10.
        add_instr(8'h2A, 0, 0);
        chk("model_lda_len", q.size(), 6);
        act_log.delete();
        run_all();
        chk("lda_e_ar_bus", int'(act_log[4][14:12]), 3);
        chk("lda_e_ld_akku", int'(act_log[5][11]), 1);

        // STA 5 with three wait cycles.
        add_instr(8'h45, 0, 3);
        act_log.delete();
        run_all();
        chk("sta_wr_cycles", count_bit(2), 4);
        chk("sta_loads_during_wr", int'(act_log[5][11:6] | act_log[8][11:6]), 0);
        chk("sta_wr_last", int'(act_log[8][2]), 1);

        // ALU op 3.
        add_instr(8'hA3, 0, 0);
        chk("model_alu_len", q.size(), 6);
        act_log.delete();
        run_all();
        chk("alu_op3_cycles", int'(act_log[4][5:4] == 2'd3) + int'(act_log[5][5:4] == 2'd3), 2);
        chk("alu_first_no_load", int'(act_log[4][11]), 0);
        chk("alu_second_bus6", int'(act_log[5][14:12]), 6);

        // JMP, MOVX, MOVY.
        add_instr(8'hC7, 1, 0);
        chk("model_jmp_len", q.size(), 6);
        add_instr(8'h61, 0, 0);
        add_instr(8'h82, 2, 0);
        run_all();

        // Reset in the middle of an LDA data wait.
        add_instr(8'h2A, 0, 8);
        run_n(8);
        pulse_reset();
        add_instr(8'h00, 0, 0);
        run_all();

`ifdef UL8_WAIT_TIMEOUT_EN
        // Ready arriving on the 16th cycle wins over the timeout.
        add_instr(8'h00, 15, 0);
        act_log.delete();
        run_all();
        chk("to_edge_rd_cycles", count_bit(3), 16);
        chk("to_edge_fault", int'(act_log[act_log.size()-1][0]), 0);

        // No ready: 16 read cycles, then HALT with fault held.
        push(rnd(), prev_ir, ov(3'd1, L_AR, 2'd0, 0, 0, 0, 0), CARE_ALL);
        for (int i = 0; i < 16; i++)
            push(1'b0, prev_ir, ov(3'd2, L_NONE, 2'd0, 1, 0, 0, 0), CARE_ALL);
        add_halt(20, 1'b1);
        act_log.delete();
        run_all();
        chk("to_rd_cycles", count_bit(3), 16);
        chk("to_fault", int'(act_log[act_log.size()-1][1:0]), 3);
        pulse_reset();
        add_instr(8'h00, 0, 0);
        run_all();
`else
        // Without the timeout a long fetch wait simply stretches the cycle.
        add_instr(8'h00, 40, 0);
        act_log.delete();
        run_all();
        chk("long_wait_rd_cycles", count_bit(3), 41);
        chk("long_wait_no_fault", count_bit(0), 0);
`endif

        // Randomised program, data waits bounded below the timeout.
        for (int n = 0; n < 250; n++) begin
            r_ir = 8'($urandom_range(0, 255));
            if (r_ir[7:5] == 3'd7) r_ir[7:5] = 3'd5;
            add_instr(r_ir, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0);
            sz = q.size();
            run_all();
        end

        // HLT: 100 idle halted cycles, then reset restarts fetch.
        add_instr(8'hE0, 0, 0);
        act_log.delete();
        run_all();
        chk("halt_cycles", count_bit(1), 100);
        pulse_reset();
        add_instr(8'h00, 0, 0);
        act_log.delete();
        run_all();
        chk("after_halt_ar", int'(act_log[0][7]), 1);
        chk("after_halt_halted", count_bit(1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
